// File: rtl/seg7_serial_tx_if.sv
// Bundle of the frame request inputs and the serial display outputs of
// seg7_serial_tx. The master drives a frame request, the slave is the transmitter.
interface seg7_serial_tx_if;
  logic        start;
  logic [31:0] Disp_num;
  logic [7:0]  point_out;
  logic [7:0]  blink_out;
  logic        seg_clk;
  logic        seg_sout;
  logic        seg_latch;
  logic        busy;
  logic        done;

  modport master (
    output start, Disp_num, point_out, blink_out,
    input  seg_clk, seg_sout, seg_latch, busy, done
  );

  modport slave (
    input  start, Disp_num, point_out, blink_out,
    output seg_clk, seg_sout, seg_latch, busy, done
  );
endinterface

// File: rtl/seg7_serial_tx.sv
// Serialises eight hex digits (with decimal points and blinking) into a 64-bit
// frame for a chain of 74HC595-style shift registers, then pulses the latch.
module seg7_serial_tx #(
  parameter int CLK_DIV    = 2,
  parameter int BLINK_BITS = 24
) (
  input  logic             clk,
  input  logic             rst,
  seg7_serial_tx_if.slave  bus,
  output logic [2:0]       dbg_state
);
  // Handshake: start is a one-way request, sampled only while idle (busy=0 and
  // done=0); requests at any other time are dropped. done pulses for one cycle
  // when the latch pulse has finished.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SHIFT_LO = 3'd1;
  localparam logic [2:0] S_SHIFT_HI = 3'd2;
  localparam logic [2:0] S_LATCH    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [2:0]            state, state_n;
  logic [7:0]            div, div_n;
  logic [6:0]            bits, bits_n;
  logic [63:0]           shreg, shreg_n;
  logic [63:0]           frame;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  div_end;
  logic                  sout_n;

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      default: hex_seg = 7'h71;
    endcase
  endfunction

  // Segments are active-low; a blinking digit in its off phase is fully blank.
  always_comb begin
    frame = '0;
    for (int i = 0; i < 8; i++) begin
      if (bus.blink_out[i] && blink_cnt[BLINK_BITS-1])
        frame[8*i +: 8] = 8'hFF;
      else
        frame[8*i +: 8] = ~{bus.point_out[i], hex_seg(bus.Disp_num[4*i +: 4])};
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div;
    bits_n  = bits;
    shreg_n = shreg;
    div_end = (div == DIV_LAST);
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          shreg_n = frame;
          bits_n  = 7'd64;
          div_n   = 8'd0;
          state_n = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        if (div_end) begin
          div_n   = 8'd0;
          state_n = S_SHIFT_HI;
        end else begin
          div_n = div + 8'd1;
        end
      end
      S_SHIFT_HI: begin
        if (div_end) begin
          div_n   = 8'd0;
          shreg_n = {shreg[62:0], 1'b0};
          bits_n  = bits - 7'd1;
          state_n = (bits == 7'd1) ? S_LATCH : S_SHIFT_LO;
        end else begin
          div_n = div + 8'd1;
        end
      end
      S_LATCH: begin
        if (div_end) begin
          div_n   = 8'd0;
          state_n = S_DONE;
        end else begin
          div_n = div + 8'd1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Data only moves when seg_clk drops; it is held through latch/done so the
  // line never toggles under a high shift clock mid-frame.
  always_comb begin
    case (state_n)
      S_SHIFT_LO: sout_n = shreg_n[63];
      S_IDLE:     sout_n = 1'b1;
      default:    sout_n = bus.seg_sout;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      div           <= 8'd0;
      bits          <= 7'd0;
      shreg         <= 64'd0;
      blink_cnt     <= '0;
      bus.seg_clk   <= 1'b1;
      bus.seg_sout  <= 1'b1;
      bus.seg_latch <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_n;
      div           <= div_n;
      bits          <= bits_n;
      shreg         <= shreg_n;
      blink_cnt     <= blink_cnt + BLINK_BITS'(1);
      bus.seg_clk   <= (state_n != S_SHIFT_LO);
      bus.seg_sout  <= sout_n;
      bus.seg_latch <= (state_n == S_LATCH);
      bus.busy      <= (state_n == S_SHIFT_LO) || (state_n == S_SHIFT_HI) ||
                       (state_n == S_LATCH);
      bus.done      <= (state_n == S_DONE);
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_seg7_serial_tx.sv
// Bench for seg7_serial_tx: fixed frame vectors, random frames against a
// digit-table model, and hand-written restart / overlap / reset sequences.
module tb_seg7_serial_tx;
  localparam int CLK_DIV    = 2;
  localparam int BLINK_BITS = 4;
  localparam int DONE_AT    = 128 * CLK_DIV + CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  seg7_serial_tx_if bus ();

  seg7_serial_tx #(.CLK_DIV(CLK_DIV), .BLINK_BITS(BLINK_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];

  // Free-running blink counter as seen by the design: cleared by reset, +1 per cycle.
  logic [BLINK_BITS-1:0] m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= '0;
    else     m_cnt <= m_cnt + BLINK_BITS'(1);
  end

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [63:0] model_frame(logic [31:0] d, logic [7:0] p,
                                              logic [7:0] b, logic ph);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i] && ph) f[8*i +: 8] = 8'hFF;
      else            f[8*i +: 8] = ~{p[i], seg_tab[d[4*i +: 4]]};
    end
    return f;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // mode bit0: extra start pulses mid-frame; bit1: scramble inputs mid-frame.
  task automatic run_frame(string name, logic [31:0] d, logic [7:0] p, logic [7:0] b,
                           int phase_req, bit use_tab, logic [63:0] tab_exp, int mode);
    logic [63:0] got, exp;
    int   nbits, latch_c, done_c, busy_c, done_at, viol, stable;
    logic pclk, psout, ph;
    got = '0; nbits = 0; latch_c = 0; done_c = 0; busy_c = 0; done_at = 0;
    viol = 0; stable = 100;
    @(negedge clk);
    if (phase_req != 2)
      for (int k = 0; k < 40 && m_cnt[BLINK_BITS-1] != phase_req[0]; k++) @(negedge clk);
    bus.Disp_num  = d;
    bus.point_out = p;
    bus.blink_out = b;
    bus.start     = 1'b1;
    ph  = m_cnt[BLINK_BITS-1];
    exp = use_tab ? tab_exp : model_frame(d, p, b, ph);
    exp_q.push_back(exp);
    pclk  = bus.seg_clk;
    psout = bus.seg_sout;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (mode[0] && (cyc == 10 || cyc == 100)) bus.start = 1'b1;
      if (mode[1]) begin
        bus.Disp_num  = $urandom;
        bus.point_out = 8'($urandom);
        bus.blink_out = 8'($urandom);
      end
      if (!pclk && bus.seg_clk) begin
        got = {got[62:0], bus.seg_sout};
        nbits++;
        if (stable < CLK_DIV) viol++;
      end
      if (bus.seg_sout !== psout) begin
        if (bus.seg_clk && bus.busy) viol++;
        stable = 1;
      end else begin
        stable++;
      end
      latch_c += int'(bus.seg_latch);
      busy_c  += int'(bus.busy);
      if (bus.done) begin
        done_c++;
        if (done_at == 0) done_at = cyc;
      end
      pclk  = bus.seg_clk;
      psout = bus.seg_sout;
      if (done_at != 0 && cyc >= done_at + 3) break;
    end
    bus.start = 1'b0;
    check({name, "_bits"},   got, exp_q.pop_front());
    check({name, "_nbits"},  64'(nbits),   64'd64);
    check({name, "_latch"},  64'(latch_c), 64'(CLK_DIV));
    check({name, "_ndone"},  64'(done_c),  64'd1);
    check({name, "_doneat"}, 64'(done_at), 64'(DONE_AT));
    check({name, "_busy"},   64'(busy_c),  64'(DONE_AT - 1));
    check({name, "_sout"},   64'(viol),    64'd0);
  endtask

  task automatic run_held();
    int first_done, second_done, ndone;
    logic busy_260, busy_261;
    first_done = 0; second_done = 0; ndone = 0; busy_260 = 1'bx; busy_261 = 1'bx;
    @(negedge clk);
    bus.Disp_num  = 32'h01234567;
    bus.point_out = 8'h00;
    bus.blink_out = 8'h00;
    bus.start     = 1'b1;
    for (int cyc = 1; cyc <= 700; cyc++) begin
      @(negedge clk);
      if (cyc == 261) bus.start = 1'b0;
      if (cyc == 260) busy_260 = bus.busy;
      if (cyc == 261) busy_261 = bus.busy;
      if (bus.done) begin
        ndone++;
        if (first_done == 0) first_done = cyc;
        else if (second_done == 0) second_done = cyc;
      end
      if (second_done != 0 && cyc >= second_done + 2) break;
    end
    bus.start = 1'b0;
    check("held_done1",  64'(first_done),  64'(DONE_AT));
    check("held_idle",   64'(busy_260),    64'd0);
    check("held_busy",   64'(busy_261),    64'd1);
    check("held_done2",  64'(second_done), 64'(2 * DONE_AT + 1));
    check("held_ndone",  64'(ndone),       64'd2);
  endtask

  task automatic run_reset_mid();
    int   nbits, bad;
    logic pclk;
    nbits = 0; bad = 0;
    @(negedge clk);
    bus.Disp_num  = 32'h89ABCDEF;
    bus.point_out = 8'h00;
    bus.blink_out = 8'h00;
    bus.start     = 1'b1;
    pclk = bus.seg_clk;
    for (int cyc = 1; cyc <= 300 && nbits < 30; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (!pclk && bus.seg_clk) nbits++;
      pclk = bus.seg_clk;
    end
    check("rst_reached_bit30", 64'(nbits), 64'd30);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs",
          {59'd0, bus.seg_clk, bus.seg_sout, bus.seg_latch, bus.busy, bus.done},
          {59'd0, 5'b11000});
    check("rst_mid_state", 64'(dbg_state), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.seg_latch || bus.done) bad++;
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.seg_latch || bus.done || bus.busy) bad++;
    end
    check("rst_no_latch_done", 64'(bad), 64'd0);
    run_frame("after_rst", 32'h01234567, 8'h00, 8'h00, 2, 1'b1, 64'hC0F9A4B0999282F8, 0);
  endtask

  typedef struct {
    logic [31:0] d;
    logic [7:0]  p;
    logic [7:0]  b;
    int          ph;
    logic [63:0] exp;
  } vec_t;

  vec_t tab[7];

  initial begin
    tab[0] = '{32'h01234567, 8'h00, 8'h00, 2, 64'hC0F9A4B0999282F8};
    tab[1] = '{32'h88888888, 8'h01, 8'h00, 2, 64'h8080808080808000};
    tab[2] = '{32'h89ABCDEF, 8'h00, 8'h00, 2, 64'h80908883C6A1868E};
    tab[3] = '{32'h01234567, 8'h80, 8'h00, 2, 64'h40F9A4B0999282F8};
    tab[4] = '{32'h01234567, 8'h00, 8'hFF, 1, 64'hFFFFFFFFFFFFFFFF};
    tab[5] = '{32'h01234567, 8'h00, 8'hFF, 0, 64'hC0F9A4B0999282F8};
    tab[6] = '{32'h01234567, 8'h00, 8'h0F, 1, 64'hC0F9A4B0FFFFFFFF};

    bus.start     = 1'b0;
    bus.Disp_num  = '0;
    bus.point_out = '0;
    bus.blink_out = '0;
    #2 rst = 1'b1;
    #3;
    check("reset_outputs",
          {59'd0, bus.seg_clk, bus.seg_sout, bus.seg_latch, bus.busy, bus.done},
          {59'd0, 5'b11000});
    check("reset_state", 64'(dbg_state), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("vec%0d", i), tab[i].d, tab[i].p, tab[i].b, tab[i].ph,
                1'b1, tab[i].exp, 0);

    run_frame("overlap_start", 32'h01234567, 8'h00, 8'h00, 2, 1'b1,
              64'hC0F9A4B0999282F8, 1);
    run_frame("scramble", 32'h89ABCDEF, 8'h00, 8'h00, 2, 1'b1,
              64'h80908883C6A1868E, 2);

    for (int r = 0; r < 6; r++) begin
      logic [31:0] d;
      logic [7:0]  p, b;
      d = $urandom;
      p = 8'($urandom);
      b = 8'($urandom);
      repeat ($urandom_range(0, 11)) @(negedge clk);
      run_frame($sformatf("rand%0d", r), d, p, b, 2, 1'b0, 64'd0, 2);
    end

    run_held();
    repeat (4) @(negedge clk);
    run_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
